fnd_score_scanner: RTL and testbench
====================================

Name: fnd_score_scanner

Overview:
Upstream feeder for the 7-segment decoder (4-bit hex code in, active-low segments out) on the Tetris score display. It latches a binary score and converts it to BCD with a sequential double-dabble, one shift per cycle. It then time-multiplexes the BCD digits across DIGITS common-anode positions. Each cycle it drives the nibble for the active digit, a one-hot active-low anode select, and a leading-zero blank flag.

Parameters:
BIN_W, 14, width of binary score input (14 bits covers 0..9999)
DIGITS, 4, number of display digits / BCD nibbles
SCAN_DIV, 50000, clock cycles each digit stays active (must be >= 2)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_score  input  BIN_W  binary score, sampled when i_load=1 in IDLE
i_load  input  1  single-cycle request to convert and display i_score
o_busy  output  1  high while conversion in progress (CONVERT or COMMIT)
o_done  output  1  one-cycle pulse when new digits are committed to display
o_nibble  output  4  BCD digit for active position; drives decoder select input
o_an  output  DIGITS  active-low one-hot anode select; bit 0 = ones digit
o_blank  output  1  high when active digit is a suppressed leading zero

Behaviour:
- Reset (i_rst=1 at a clock edge) is synchronous and applies in any state, including mid-conversion:
  - state=IDLE, shift/BCD work regs=0, display regs=0, prescaler=0, digit index=0.
  - Outputs: o_busy=0, o_done=0, o_an=~1 (4'b1110 at default), o_nibble=0, o_blank=0.
  - A conversion in progress is discarded. Display shows 0.
- Conversion FSM: IDLE -> CONVERT -> COMMIT -> IDLE.
  - IDLE: if i_load=1, capture i_score and saturate it. If the value > 10^DIGITS-1, load 10^DIGITS-1 (9999). Clear BCD work reg, clear counter, go to CONVERT.
  - CONVERT: each cycle, every BCD nibble >= 5 gets +3. Then the combined {bcd, bin} register shifts left by 1, taking in the bin MSB. After exactly BIN_W shifts, go to COMMIT.
  - COMMIT: copy BCD work reg to display regs, assert o_done for this cycle only, go to IDLE.
- Timing: i_load sampled at edge N gives:
  - o_busy=1 from edge N+1 through edge N+BIN_W+1.
  - Display regs and o_done=1 updated at edge N+BIN_W+1.
  - o_busy=0 at edge N+BIN_W+2.
- i_load while o_busy=1 is ignored (no queueing). A load in the same cycle COMMIT exits is also ignored; the caller waits for o_busy=0.
- Display regs hold the previous value throughout conversion. No partial BCD is ever shown.
- Scanner runs continuously and independently of the FSM:
  - Prescaler counts 0..SCAN_DIV-1. On wrap to 0, the digit index increments mod DIGITS (DIGITS-1 wraps to 0).
  - o_an = ~(1 << index). Exactly one bit is low at all times, including during reset.
  - o_nibble = display nibble[index]. o_an and o_nibble are both derived from the registered index, so they change on the same edge. No cross-digit glitch.
  - o_blank=1 iff index > 0 and display nibbles index..DIGITS-1 are all zero. The ones digit is never blanked, so value 0 shows a single "0".
- A display update in COMMIT does not reset the prescaler or the index.
- All arithmetic is unsigned. BCD work reg width = 4*DIGITS. Iteration counter width = clog2(BIN_W+1).

Test Plan:
- Reset then idle (SCAN_DIV=4): o_an cycles 1110,1101,1011,0111, each held 4 clocks, then repeats. o_nibble=0 always. o_blank=0 on digit 0, 1 on digits 1..3.
- i_score=1234, i_load pulse at edge N: o_busy high edges N+1..N+15, o_done pulse at N+15. Afterwards o_nibble per index = 4,3,2,1 and o_blank=0 throughout.
- i_score=70: digits 0,7,0,0. o_blank=1 only for index 2 and 3; index 0 shows 0 and is not blanked.
- i_score=12000 (>9999): display saturates to 9,9,9,9. o_done pulse as normal.
- Show 1234, then load 5678 and pulse i_load again at N+5 with i_score=42: second pulse ignored. Display keeps 1234 until N+15, then becomes 5678, never 42.
- Assert i_rst at N+7 during a conversion of 9999: next cycle o_busy=0, display 0, o_an=1110, no o_done pulse ever occurs for that conversion.

Source files
------------

// File: rtl/fnd_score_scanner.sv
// fnd_score_scanner
//   Feeds the 7-segment decoder of the score display. A binary score is
//   latched, saturated to the largest value the display can show, and
//   converted to BCD with a sequential double-dabble (one shift per clock).
//   The committed BCD digits are then time-multiplexed across DIGITS
//   common-anode positions by a free-running scanner.
//
// Ports
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_score   binary score, sampled when i_load=1 while idle
//   i_load    single-cycle request to convert and display i_score
//   o_busy    high while a conversion is in progress (CONVERT or COMMIT)
//   o_done    one-cycle pulse while new digits are being committed
//   o_nibble  BCD digit of the active position (decoder select input)
//   o_an      active-low one-hot anode select, bit 0 = ones digit
//   o_blank   high when the active digit is a suppressed leading zero
module fnd_score_scanner #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BIN_W-1:0]  i_score,
  input  logic              i_load,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_nibble,
  output logic [DIGITS-1:0] o_an,
  output logic              o_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SH_W  = BCD_W + BIN_W;
  // Largest value the display can show (all nines).
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg,   bin_next;
  logic [BCD_W-1:0]   bcd_reg,   bcd_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic [BCD_W-1:0]   disp_reg,  disp_next;
  logic [PRE_W-1:0]   presc_reg, presc_next;
  logic [IDX_W-1:0]   idx_reg,   idx_next;

  logic [BIN_W-1:0]   score_sat;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SH_W-1:0]    shift_val;
  logic [DIGITS-1:0]  upper_zero;

  // Scores beyond the display range are clamped rather than wrapped.
  always_comb begin
    score_sat = i_score;
    if (64'(i_score) > MAX_VAL) begin
      score_sat = BIN_W'(MAX_VAL);
    end
  end

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
  // that doubling carries correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_reg[gi*4 +: 4] + 4'd3) :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shift_val = {bcd_adj, bin_reg} << 1;

  // upper_zero[i]: displayed nibbles i..DIGITS-1 are all zero.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign upper_zero[gi] = (disp_reg[BCD_W-1:gi*4] == '0);
    end
  endgenerate

  // Conversion FSM and scanner next-state logic.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    disp_next  = disp_reg;
    presc_next = presc_reg;
    idx_next   = idx_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (i_load) begin
          bin_next   = score_sat;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_next = shift_val[SH_W-1:BIN_W];
        bin_next = shift_val[BIN_W-1:0];
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(BIN_W - 1)) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // i_load is deliberately not looked at here: a request arriving
        // on the exit cycle is dropped, callers wait for o_busy=0.
        disp_next  = bcd_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Free-running scanner, independent of conversions.
    if (presc_reg == PRE_W'(SCAN_DIV - 1)) begin
      presc_next = '0;
      idx_next   = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      presc_next = presc_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      disp_reg  <= '0;
      presc_reg <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      disp_reg  <= disp_next;
      presc_reg <= presc_next;
      idx_reg   <= idx_next;
    end
  end

  // All display outputs derive from the registered index and display regs,
  // so anode and nibble always switch on the same edge.
  assign o_busy   = (state_reg != ST_IDLE);
  assign o_done   = (state_reg == ST_COMMIT);
  assign o_an     = ~(DIGITS'(1) << idx_reg);
  assign o_nibble = disp_reg[{idx_reg, 2'b00} +: 4];
  // The ones digit is never blanked so a zero score shows a single "0".
  assign o_blank  = (idx_reg != '0) && upper_zero[idx_reg];

endmodule

// File: tb/tb_fnd_score_scanner.sv
// Testbench for fnd_score_scanner: table of scores with expected displayed
// values, hand-written sequences for ignored loads and mid-conversion reset,
// and random scores checked against an arithmetic reference model.
module tb_fnd_score_scanner;

  localparam int BIN_W    = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int MAX_VAL  = 9999;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [BIN_W-1:0]  score;
  logic              busy;
  logic              done;
  logic [3:0]        nibble;
  logic [DIGITS-1:0] an;
  logic              blank;

  int n_vec = 0;
  int n_err = 0;
  int scan_cnt = 0;     // clock edges since the last reset edge
  int disp_model = 0;   // value the display should currently show

  fnd_score_scanner #(
    .BIN_W    (BIN_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_score  (score),
    .i_load   (load),
    .o_busy   (busy),
    .o_done   (done),
    .o_nibble (nibble),
    .o_an     (an),
    .o_blank  (blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) scan_cnt <= 0;
    else     scan_cnt <= scan_cnt + 1;
  end

  typedef struct {
    int score;
    int shown;
  } vec_t;

  vec_t vecs[10];

  function automatic int pow10(int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic int sat_of(int v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected {an, nibble, blank} from the scan position and the model value.
  task automatic check_scan();
    int idx;
    logic [3:0] e_an;
    logic [3:0] e_nib;
    logic       e_blank;
    idx     = (scan_cnt / SCAN_DIV) % DIGITS;
    e_an    = ~(4'b0001 << idx);
    e_nib   = 4'((disp_model / pow10(idx)) % 10);
    e_blank = (idx > 0) && (disp_model < pow10(idx));
    chk("scan{an,nibble,blank}", {an, nibble, blank}, {e_an, e_nib, e_blank});
  endtask

  // Load sc; optionally pulse a second load (score 42) before tick pulse_at.
  task automatic run_load(input int sc, input int shown, input int pulse_at);
    score = BIN_W'(sc);
    load  = 1'b1;
    for (int m = 1; m <= 17; m++) begin
      if (m == pulse_at && m > 1) begin
        score = 14'd42;
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
      if (m == 16) disp_model = shown;
      chk("busy", busy, (m <= 15));
      chk("done", done, (m == 15));
      check_scan();
    end
    $display("load score=%0d extra_pulse=%0d -> display %0d", sc, pulse_at, shown);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      check_scan();
    end
  endtask

  initial begin
    vecs[0] = '{1234, 1234};
    vecs[1] = '{70, 70};
    vecs[2] = '{12000, 9999};
    vecs[3] = '{0, 0};
    vecs[4] = '{9999, 9999};
    vecs[5] = '{10000, 9999};
    vecs[6] = '{16383, 9999};
    vecs[7] = '{5, 5};
    vecs[8] = '{100, 100};
    vecs[9] = '{1008, 1008};

    rst   = 1'b1;
    load  = 1'b0;
    score = '0;
    tick(); tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_an", an, 4'b1110);
    check_scan();
    rst = 1'b0;

    // Idle scan of a zero display: two full rotations.
    idle_cycles(2 * DIGITS * SCAN_DIV);

    // Table-driven loads, each followed by a full scan rotation.
    for (int i = 0; i < 10; i++) begin
      run_load(vecs[i].score, vecs[i].shown, 0);
      idle_cycles(DIGITS * SCAN_DIV);
    end

    // Load during conversion is ignored.
    run_load(1234, 1234, 0);
    run_load(5678, 5678, 6);
    idle_cycles(DIGITS * SCAN_DIV + 3);
    // Load on the cycle COMMIT exits is ignored.
    run_load(1111, 1111, 16);
    idle_cycles(DIGITS * SCAN_DIV + 3);

    // Reset in the middle of converting 9999.
    score = 14'd9999;
    load  = 1'b1;
    for (int m = 1; m <= 7; m++) begin
      tick();
      load = 1'b0;
      chk("pre_rst_busy", busy, 1'b1);
      check_scan();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    disp_model = 0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_an", an, 4'b1110);
    check_scan();
    $display("reset during conversion of 9999 -> display 0");
    idle_cycles(3 * DIGITS * SCAN_DIV);

    // Random scores against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      int sc;
      sc = (i % 4 == 0) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 16383));
      run_load(sc, sat_of(sc), 0);
      idle_cycles(int'($urandom_range(0, 2 * DIGITS * SCAN_DIV)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
